// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl
// Time-multiplexed scan controller for a four-digit seven-segment display.
// The controller double-buffers a four-digit BCD value plus decimal points.
// It scans one digit per slot, with a short dark gap at the start of each
// slot so the previous digit does not ghost into the next one. New values
// are transferred only at frame boundaries, so a displayed frame never tears.
//
// Optional build macro: DISP_LZS_EN
//   When defined, leading zeros are suppressed: digit i (3..1) shows no
//   segments while it and every more-significant nibble are zero.
//   When undefined, zeros display as '0' in every position.
module disp_scan_ctrl #(
  parameter int SCAN_DIV     = 1024,  // clock cycles per digit slot, >= 2
  parameter int BLANK_CYCLES = 16     // dark cycles at slot start, < SCAN_DIV
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] Value,
  input  logic [3:0]  DpMask,
  input  logic        Load,
  input  logic        Blank,
  output logic        LoadAck,
  output logic [3:0]  nDigit,
  output logic [6:0]  Seg,
  output logic        DP
);

  localparam int              CntW     = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CntW-1:0] CntLast  = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] CntBlank = CntW'(BLANK_CYCLES);
  localparam logic [1:0]      IdxLast  = 2'd3;

  // Scan position
  logic [CntW-1:0] cnt;
  logic [1:0]      idx;

  // Shadow (written by Load) and display (what is being scanned) buffers
  logic [15:0] shadowVal;
  logic [3:0]  shadowDp;
  logic        pending;
  logic [15:0] dispVal;
  logic [3:0]  dispDp;

  // Transfer happened at the last edge; LoadAck follows one cycle later so it
  // lines up with the first output cycle that actually shows the new value.
  logic        ackPend;

  logic        slotEnd;
  logic        frameEnd;
  logic        inBlank;
  logic [6:0]  digitSeg [4];

  // BCD to seven-segment (bit0 = A ... bit6 = G); A-E blank, F is a dash
  function automatic logic [6:0] decodeSeg(input logic [3:0] nib);
    logic [6:0] seg;
    seg = 7'h00;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hF:    seg = 7'h40;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  assign slotEnd  = (cnt == CntLast);
  assign frameEnd = slotEnd && (idx == IdxLast);
  assign inBlank  = (cnt < CntBlank);

  // Per-digit segment patterns decoded from the display register
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : gDigit
      logic [3:0] nib;
      assign nib = dispVal[gi*4 +: 4];
`ifdef DISP_LZS_EN
      if (gi == 0) begin : gUnits
        // the rightmost digit always shows, so a plain zero reads as '0'
        assign digitSeg[gi] = decodeSeg(nib);
      end else begin : gUpper
        // dark when this nibble and everything to its left is zero
        assign digitSeg[gi] = (dispVal[15:gi*4] == '0) ? 7'h00 : decodeSeg(nib);
      end
`else
      assign digitSeg[gi] = decodeSeg(nib);
`endif
    end
  endgenerate

  // Slot prescaler and digit index; these never stop, Blank only masks outputs
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (slotEnd) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CntW'(1);
    end
  end

  // Shadow capture and frame-boundary transfer into the display register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      shadowVal <= '0;
      shadowDp  <= '0;
      pending   <= 1'b0;
      dispVal   <= '0;
      dispDp    <= '0;
      ackPend   <= 1'b0;
      LoadAck   <= 1'b0;
    end else begin
      ackPend <= 1'b0;
      LoadAck <= ackPend;
      if (frameEnd) begin
        // a Load on the boundary itself bypasses the shadow
        if (Load) begin
          dispVal <= Value;
          dispDp  <= DpMask;
          ackPend <= 1'b1;
        end else if (pending) begin
          dispVal <= shadowVal;
          dispDp  <= shadowDp;
          ackPend <= 1'b1;
        end
        pending <= 1'b0;
      end else if (Load) begin
        // repeated loads within a frame simply overwrite; one ack results
        shadowVal <= Value;
        shadowDp  <= DpMask;
        pending   <= 1'b1;
      end
    end
  end

  // Registered pad drive: dark during the slot gap or while Blank is high
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      nDigit <= 4'hF;
      Seg    <= 7'h00;
      DP     <= 1'b0;
    end else if (Blank || inBlank) begin
      nDigit <= 4'hF;
      Seg    <= 7'h00;
      DP     <= 1'b0;
    end else begin
      nDigit <= ~(4'b0001 << idx);
      Seg    <= digitSeg[idx];
      DP     <= dispDp[idx];
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl
// Directed plus random stimulus for disp_scan_ctrl with a small slot size.
// Expected outputs come from a timeline model: the scan position is derived
// from the number of cycles since reset, and the shown value changes only at
// the last cycle of each frame.
`timescale 1ns/1ps
module tb_disp_scan_ctrl;

  localparam int SD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 4 * SD;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] Value = '0;
  logic [3:0]  DpMask = '0;
  logic        Load = 1'b0;
  logic        Blank = 1'b0;
  logic        LoadAck;
  logic [3:0]  nDigit;
  logic [6:0]  Seg;
  logic        DP;

  disp_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .Value  (Value),
    .DpMask (DpMask),
    .Load   (Load),
    .Blank  (Blank),
    .LoadAck(LoadAck),
    .nDigit (nDigit),
    .Seg    (Seg),
    .DP     (DP)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;

  // model state
  int          t;            // cycles since reset release
  logic [15:0] mDisp;
  logic [3:0]  mDispDp;
  logic [15:0] mShadow;
  logic [3:0]  mShadowDp;
  logic        mPend;
  logic        mXferPrev;
  logic [6:0]  segTab [16];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  // what the pads should show during the cycle after cycle tt
  function automatic void expectOut(input int tt, input logic [15:0] dv, input logic [3:0] dd,
                                    input logic bl, output logic [3:0] en,
                                    output logic [6:0] sg, output logic ed);
    int c;
    int d;
    int nib;
    c  = tt % SD;
    d  = (tt / SD) % 4;
    en = 4'hF;
    sg = 7'h00;
    ed = 1'b0;
    if (!bl && c >= BC) begin
      en[d] = 1'b0;
      nib   = int'((dv >> (4 * d)) & 16'h000F);
      sg    = segTab[nib];
`ifdef DISP_LZS_EN
      if (d != 0 && (dv >> (4 * d)) == 16'h0000) sg = 7'h00;
`endif
      ed = dd[d];
    end
  endfunction

  task automatic modelReset();
    t         = 0;
    mDisp     = '0;
    mDispDp   = '0;
    mShadow   = '0;
    mShadowDp = '0;
    mPend     = 1'b0;
    mXferPrev = 1'b0;
  endtask

  // one clock cycle: drive inputs, predict, clock, compare
  task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] dp, input logic bl);
    logic [3:0] eN;
    logic [6:0] eS;
    logic       eD;
    logic       eA;
    logic       xfer;
    Load   = ld;
    Value  = v;
    DpMask = dp;
    Blank  = bl;
    if (ld) $display("load t=%0d slot=%0d value=%h dp=%b", t, (t / SD) % 4, v, dp);
    expectOut(t, mDisp, mDispDp, bl, eN, eS, eD);
    eA   = mXferPrev;
    xfer = 1'b0;
    if ((t % FRAME) == FRAME - 1) begin
      xfer = ld || mPend;
      if (ld) begin
        mDisp   = v;
        mDispDp = dp;
      end else if (mPend) begin
        mDisp   = mShadow;
        mDispDp = mShadowDp;
      end
      mPend = 1'b0;
    end else if (ld) begin
      mShadow   = v;
      mShadowDp = dp;
      mPend     = 1'b1;
    end
    @(posedge Clock);
    #1;
    chk("nDigit", 16'(nDigit), 16'(eN));
    chk("Seg", 16'(Seg), 16'(eS));
    chk("DP", 16'(DP), 16'(eD));
    chk("LoadAck", 16'(LoadAck), 16'(eA));
    mXferPrev = xfer;
    t++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'($urandom), 4'($urandom), 1'b0);
  endtask

  task automatic idleUntil(input int phase);
    for (int i = 0; i < FRAME && (t % FRAME) != phase; i++)
      step(1'b0, 16'($urandom), 4'($urandom), 1'b0);
  endtask

  function automatic logic [15:0] randBcd();
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < 4; k++)
      r[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
    return r;
  endfunction

  initial begin
    segTab[0]  = 7'h3F; segTab[1]  = 7'h06; segTab[2]  = 7'h5B; segTab[3]  = 7'h4F;
    segTab[4]  = 7'h66; segTab[5]  = 7'h6D; segTab[6]  = 7'h7D; segTab[7]  = 7'h07;
    segTab[8]  = 7'h7F; segTab[9]  = 7'h6F; segTab[10] = 7'h00; segTab[11] = 7'h00;
    segTab[12] = 7'h00; segTab[13] = 7'h00; segTab[14] = 7'h00; segTab[15] = 7'h40;
    modelReset();

    // power-on reset, checked before any clock edge
    #2 Reset = 1'b1;
    #1;
    chk("rst_nDigit", 16'(nDigit), 16'h000F);
    chk("rst_Seg", 16'(Seg), 16'h0000);
    chk("rst_DP", 16'(DP), 16'h0000);
    chk("rst_LoadAck", 16'(LoadAck), 16'h0000);
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    modelReset();

    // first load, shown after the first frame boundary
    step(1'b1, 16'h1234, 4'b0000, 1'b0);
    idle(2 * FRAME);

    // load while digit 1 is scanning; 1234 stays until the boundary
    idleUntil(SD + 3);
    step(1'b1, 16'h5678, 4'b0100, 1'b0);
    idle(FRAME + 4);

    // two loads in one frame give one ack, last value wins
    idleUntil(2);
    step(1'b1, 16'h1111, 4'b0001, 1'b0);
    idle(5);
    step(1'b1, 16'h2222, 4'b0000, 1'b0);
    idle(2 * FRAME);

    // Blank raised mid-DRIVE, then released without phase slip
    idleUntil(SD + 4);
    for (int i = 0; i < 5; i++) step(1'b0, 16'($urandom), 4'($urandom), 1'b1);
    idle(FRAME);

    // leading zeros and a dash
    step(1'b1, 16'h000F, 4'b0010, 1'b0);
    idle(2 * FRAME);

    // load on the boundary cycle itself goes straight to the display
    idleUntil(FRAME - 1);
    step(1'b1, 16'h9087, 4'b1001, 1'b0);
    idle(FRAME + 2);

    // random loads, values and blanking
    for (int i = 0; i < 30 * FRAME; i++) begin
      logic ld;
      logic bl;
      ld = ($urandom_range(0, 19) == 0);
      bl = ($urandom_range(0, 15) == 0);
      step(ld, randBcd(), 4'($urandom), bl);
    end

    // reset mid-slot with a lit digit and a load pending
    step(1'b1, 16'h8888, 4'b1111, 1'b0);
    idle(FRAME);
    idleUntil(SD + 5);
    step(1'b1, 16'h4321, 4'b0011, 1'b0);
    idle(1);
    chk("pre_rst_lit", 16'(nDigit), 16'h000D);
    #2 Reset = 1'b1;
    Load = 1'b0;
    #1;
    chk("async_nDigit", 16'(nDigit), 16'h000F);
    chk("async_Seg", 16'(Seg), 16'h0000);
    chk("async_DP", 16'(DP), 16'h0000);
    chk("async_LoadAck", 16'(LoadAck), 16'h0000);
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    modelReset();
    idle(2 * FRAME);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
